// File: rtl/dual_port_bram_pkg.sv
// Shared constants, FSM state encoding and lane-count helper for the
// dual-port block RAM and its output stage.
package dual_port_bram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic int calc_nb(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/dual_port_bram_out_stage.sv
// Per-port read output stage: captures raw read data on an accepted request
// and produces the valid flag, with an optional extra pipeline register.
module bram_out_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid
);

  logic [DATA_WIDTH-1:0] stg_data_q, stg_data_d;
  logic                  stg_valid_q, stg_valid_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;

  always_comb begin
    stg_data_d  = stg_data_q;
    stg_valid_d = accept;
    dout_d      = dout_q;
    valid_d     = 1'b0;
    if (accept) begin
      stg_data_d = rdata;
    end
    // dout only moves when a result arrives, so it holds while valid is low
    if (OUT_REG != 0) begin
      valid_d = stg_valid_q;
      if (stg_valid_q) begin
        dout_d = stg_data_q;
      end
    end else begin
      valid_d = accept;
      if (accept) begin
        dout_d = rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_data_q  <= '0;
      stg_valid_q <= 1'b0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      stg_data_q  <= stg_data_d;
      stg_valid_q <= stg_valid_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;

endmodule

// File: rtl/dual_port_bram.sv
// True dual-port RAM with byte-lane write enables, selectable same-port
// read-during-write, optional output register and a post-reset clear sequencer.
module dual_port_bram
  import dual_port_bram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_W         = 8,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         busy,
  input  logic                         a_en,
  input  logic [DATA_WIDTH/BYTE_W-1:0] a_we,
  input  logic [ADDR_WIDTH-1:0]        a_addr,
  input  logic [DATA_WIDTH-1:0]        a_din,
  output logic [DATA_WIDTH-1:0]        a_dout,
  output logic                         a_valid,
  input  logic                         b_en,
  input  logic [DATA_WIDTH/BYTE_W-1:0] b_we,
  input  logic [ADDR_WIDTH-1:0]        b_addr,
  input  logic [DATA_WIDTH-1:0]        b_din,
  output logic [DATA_WIDTH-1:0]        b_dout,
  output logic                         b_valid
);

  localparam int NB    = calc_nb(DATA_WIDTH, BYTE_W);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  clr_we;
  logic                  a_acc, b_acc;
  logic [NB-1:0]         a_wr, b_wr;
  logic [DATA_WIDTH-1:0] a_rdata, b_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = !rst;
        cnt_d  = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = ST_READY;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy  = (state_q == ST_CLEAR);
  assign a_acc = a_en && !busy && !rst;
  assign b_acc = b_en && !busy && !rst;
  assign a_wr  = a_acc ? a_we : '0;
  assign b_wr  = b_acc ? b_we : '0;

  // One narrow array per lane keeps byte enables independent and inference-friendly
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [BYTE_W-1:0] mem_lane [DEPTH];

    always_ff @(posedge clk) begin
      if (clr_we) begin
        mem_lane[cnt_q] <= '0;
      end else begin
        // A is written last so it wins a same-address, same-lane collision
        if (b_wr[gi]) begin
          mem_lane[b_addr] <= b_din[gi*BYTE_W +: BYTE_W];
        end
        if (a_wr[gi]) begin
          mem_lane[a_addr] <= a_din[gi*BYTE_W +: BYTE_W];
        end
      end
    end

    // Write-first only forwards the port's own data; the other port sees old data
    assign a_rdata[gi*BYTE_W +: BYTE_W] =
      (RDW_MODE == RDW_WRITE_FIRST && a_wr[gi]) ? a_din[gi*BYTE_W +: BYTE_W]
                                                : mem_lane[a_addr];
    assign b_rdata[gi*BYTE_W +: BYTE_W] =
      (RDW_MODE == RDW_WRITE_FIRST && b_wr[gi]) ? b_din[gi*BYTE_W +: BYTE_W]
                                                : mem_lane[b_addr];
  end

  bram_out_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_REG   (OUT_REG)
  ) u_out_a (
    .clk   (clk),
    .rst   (rst),
    .accept(a_acc),
    .rdata (a_rdata),
    .dout  (a_dout),
    .valid (a_valid)
  );

  bram_out_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_REG   (OUT_REG)
  ) u_out_b (
    .clk   (clk),
    .rst   (rst),
    .accept(b_acc),
    .rdata (b_rdata),
    .dout  (b_dout),
    .valid (b_valid)
  );

endmodule

// File: tb/tb_dual_port_bram.sv
// Drives two RAM configurations (read-first/latency 1 and write-first/latency 2)
// with shared stimulus and checks both against a word-level reference model.
module tb_dual_port_bram;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int NB = DW / BW;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_en, b_en;
  logic [NB-1:0] a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din;

  logic          busy0, busy1;
  logic [DW-1:0] a_dout0, b_dout0, a_dout1, b_dout1;
  logic          a_valid0, b_valid0, a_valid1, b_valid1;

  always #5 clk = ~clk;

  dual_port_bram #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_W(BW),
    .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clk(clk), .rst(rst), .busy(busy0),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout0), .a_valid(a_valid0),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout0), .b_valid(b_valid0)
  );

  dual_port_bram #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_W(BW),
    .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clk(clk), .rst(rst), .busy(busy1),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout1), .a_valid(a_valid1),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout1), .b_valid(b_valid1)
  );

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  // Reference model: word array, clear countdown, expected outputs per DUT
  logic [DW-1:0] mm [DEPTH];
  int            busy_left = DEPTH;
  logic [DW-1:0] e_ad0 = '0, e_bd0 = '0, e_ad1 = '0, e_bd1 = '0;
  logic          e_av0 = 1'b0, e_bv0 = 1'b0, e_av1 = 1'b0, e_bv1 = 1'b0;
  logic [DW-1:0] p_ad = '0, p_bd = '0;
  logic          p_av = 1'b0, p_bv = 1'b0;

  typedef struct {
    logic          a_en;
    logic [NB-1:0] a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din;
    logic          b_en;
    logic [NB-1:0] b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_din;
    bit            chk_a;
    logic [DW-1:0] exp_a_rf;
    logic [DW-1:0] exp_a_wf;
    bit            chk_b;
    logic [DW-1:0] exp_b;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [NB-1:0] we);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++)
      if (we[i]) r[i*BW +: BW] = new_w[i*BW +: BW];
    return r;
  endfunction

  function automatic vec_t mk(input logic ae, input logic [NB-1:0] awe, input logic [AW-1:0] aa,
                              input logic [DW-1:0] ad, input logic be, input logic [NB-1:0] bwe,
                              input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                              input bit ca, input logic [DW-1:0] erf, input logic [DW-1:0] ewf,
                              input bit cb, input logic [DW-1:0] eb);
    vec_t v;
    v.a_en = ae; v.a_we = awe; v.a_addr = aa; v.a_din = ad;
    v.b_en = be; v.b_we = bwe; v.b_addr = ba; v.b_din = bd;
    v.chk_a = ca; v.exp_a_rf = erf; v.exp_a_wf = ewf; v.chk_b = cb; v.exp_b = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  task automatic idle();
    a_en = 1'b0; a_we = '0; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_we = '0; b_addr = '0; b_din = '0;
  endtask

  task automatic drive_a(input logic [NB-1:0] we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    a_en = 1'b1; a_we = we; a_addr = addr; a_din = din;
  endtask

  // One clock: predict from the rules, advance, compare every output of both DUTs
  task automatic step();
    logic [DW-1:0] ra, rb, ra_wf, rb_wf;
    bit acc_a, acc_b;
    acc_a = a_en && (busy_left == 0) && !rst;
    acc_b = b_en && (busy_left == 0) && !rst;
    ra = mm[a_addr];
    rb = mm[b_addr];
    ra_wf = acc_a ? merge(ra, a_din, a_we) : ra;
    rb_wf = acc_b ? merge(rb, b_din, b_we) : rb;
    if (acc_b) mm[b_addr] = merge(mm[b_addr], b_din, b_we);
    if (acc_a) mm[a_addr] = merge(mm[a_addr], a_din, a_we);
    @(posedge clk);
    #1;
    cycle++;
    if (rst) begin
      busy_left = DEPTH;
      e_ad0 = '0; e_bd0 = '0; e_ad1 = '0; e_bd1 = '0;
      e_av0 = 0; e_bv0 = 0; e_av1 = 0; e_bv1 = 0;
      p_ad = '0; p_bd = '0; p_av = 0; p_bv = 0;
    end else begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0)
          for (int i = 0; i < DEPTH; i++) mm[i] = '0;
      end
      e_av0 = acc_a; if (acc_a) e_ad0 = ra;
      e_bv0 = acc_b; if (acc_b) e_bd0 = rb;
      e_av1 = p_av;  if (p_av) e_ad1 = p_ad;
      e_bv1 = p_bv;  if (p_bv) e_bd1 = p_bd;
      p_av = acc_a;  if (acc_a) p_ad = ra_wf;
      p_bv = acc_b;  if (acc_b) p_bd = rb_wf;
    end
    chk("busy0", 32'(busy0), 32'(busy_left > 0));
    chk("busy1", 32'(busy1), 32'(busy_left > 0));
    chk("a_valid0", 32'(a_valid0), 32'(e_av0));
    chk("b_valid0", 32'(b_valid0), 32'(e_bv0));
    chk("a_valid1", 32'(a_valid1), 32'(e_av1));
    chk("b_valid1", 32'(b_valid1), 32'(e_bv1));
    chk("a_dout0", a_dout0, e_ad0);
    chk("b_dout0", b_dout0, e_bd0);
    chk("a_dout1", a_dout1, e_ad1);
    chk("b_dout1", b_dout1, e_bd1);
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy0 && n < 100) begin
      step();
      n++;
    end
    chk(name, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    idle();

    // Power-up reset and first clear
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    count_busy("busy_len_first");

    // Preload nonzero, then a one-cycle reset must zero everything
    for (int i = 0; i < DEPTH; i++) begin
      drive_a('1, AW'(i), 32'hA5000000 | 32'(i + 1));
      step();
    end
    idle();
    rst = 1'b1; step(); rst = 1'b0;
    count_busy("busy_len_clear");
    for (int i = 0; i < DEPTH; i++) begin
      drive_a('0, AW'(i), '0);
      step();
      chk("clear_read", a_dout0, 32'h0);
      chk("clear_valid", 32'(a_valid0), 32'h1);
    end
    idle(); step();

    // Directed table: byte enables, same-port RDW, cross-port collisions
    tbl[0] = mk(1, 4'hF, 3, 32'hAABBCCDD, 0, 4'h0, 0, 0,            0, 0, 0, 0, 0);
    tbl[1] = mk(1, 4'h5, 3, 32'h11223344, 0, 4'h0, 0, 0,            0, 0, 0, 0, 0);
    tbl[2] = mk(1, 4'h0, 3, 0,            0, 4'h0, 0, 0,            1, 32'hAA22CC44, 32'hAA22CC44, 0, 0);
    tbl[3] = mk(1, 4'hF, 5, 32'h1,        0, 4'h0, 0, 0,            0, 0, 0, 0, 0);
    tbl[4] = mk(1, 4'hF, 5, 32'h2,        0, 4'h0, 0, 0,            1, 32'h1, 32'h2, 0, 0);
    tbl[5] = mk(1, 4'h0, 5, 0,            0, 4'h0, 0, 0,            1, 32'h2, 32'h2, 0, 0);
    tbl[6] = mk(1, 4'h3, 7, 32'hFFFFFFFF, 1, 4'hF, 7, 32'h12345678, 0, 0, 0, 0, 0);
    tbl[7] = mk(1, 4'h0, 7, 0,            0, 4'h0, 0, 0,            1, 32'h1234FFFF, 32'h1234FFFF, 0, 0);
    tbl[8] = mk(1, 4'hF, 7, 32'hCAFEBABE, 1, 4'h0, 7, 0,            0, 0, 0, 1, 32'h1234FFFF);
    tbl[9] = mk(0, 4'h0, 0, 0,            1, 4'h0, 7, 0,            0, 0, 0, 1, 32'hCAFEBABE);
    for (int i = 0; i < NV; i++) begin
      a_en = tbl[i].a_en; a_we = tbl[i].a_we; a_addr = tbl[i].a_addr; a_din = tbl[i].a_din;
      b_en = tbl[i].b_en; b_we = tbl[i].b_we; b_addr = tbl[i].b_addr; b_din = tbl[i].b_din;
      step();
      if (tbl[i].chk_a) chk("tbl_a_rf", a_dout0, tbl[i].exp_a_rf);
      if (tbl[i].chk_b) chk("tbl_b_rf", b_dout0, tbl[i].exp_b);
      if (i > 0 && tbl[i-1].chk_a) chk("tbl_a_wf", a_dout1, tbl[i-1].exp_a_wf);
      if (i > 0 && tbl[i-1].chk_b) chk("tbl_b_wf", b_dout1, tbl[i-1].exp_b);
    end
    idle(); step();
    if (tbl[NV-1].chk_b) chk("tbl_b_wf", b_dout1, tbl[NV-1].exp_b);

    // Latency-2 back-to-back reads of addrs 1,2,3
    drive_a('1, 1, 32'h01010101); step();
    drive_a('1, 2, 32'h02020202); step();
    drive_a('1, 3, 32'h03030303); step();
    idle(); step(); step();
    drive_a('0, 1, '0); step();
    chk("oreg_v0", 32'(a_valid1), 32'h0);
    drive_a('0, 2, '0); step();
    chk("oreg_v1", 32'(a_valid1), 32'h1); chk("oreg_d1", a_dout1, 32'h01010101);
    drive_a('0, 3, '0); step();
    chk("oreg_v2", 32'(a_valid1), 32'h1); chk("oreg_d2", a_dout1, 32'h02020202);
    idle(); step();
    chk("oreg_v3", 32'(a_valid1), 32'h1); chk("oreg_d3", a_dout1, 32'h03030303);
    step();
    chk("oreg_v4", 32'(a_valid1), 32'h0); chk("oreg_hold", a_dout1, 32'h03030303);

    // Reset at clear cycle 9, with a write attempted while busy
    drive_a('1, 2, 32'h77777777); step(); idle();
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("midclr_busy", 32'(busy0), 32'h1);
    n = 0;
    while (busy0 && n < 100) begin
      if (n == 3) drive_a('1, 2, 32'hDEADBEEF); else idle();
      step();
      if (n == 3) chk("busy_req_valid", 32'(a_valid0), 32'h0);
      n++;
    end
    chk("busy_len_restart", 32'(n), 32'(DEPTH));
    drive_a('0, 2, '0); step();
    chk("busy_req_nowrite", a_dout0, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      a_en = 1'($urandom_range(0, 1)); a_we = NB'($urandom); a_addr = AW'($urandom); a_din = $urandom;
      b_en = 1'($urandom_range(0, 1)); b_we = NB'($urandom); b_addr = AW'($urandom); b_din = $urandom;
      if ($urandom_range(0, 3) == 0) a_we = '0;
      if ($urandom_range(0, 3) == 0) b_we = '0;
      step();
    end
    idle(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dual_port_bram.md
Name: dual_port_bram

Overview:
- True dual-port synchronous block RAM with per-byte write enables, selectable read-during-write behaviour and an optional output pipeline register.
- Includes a post-reset clear sequencer that zeroes every word before either port is serviced.
- Replaces single-port byte-wide memories where a CPU fetch/data path or a CPU/DMA pair needs two independent ports into one array.

Parameters:
- ADDR_WIDTH, 16, address bits per port; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width; must be a multiple of BYTE_W.
- BYTE_W, 8, bits per write lane; NB = DATA_WIDTH/BYTE_W lanes.
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data).
- OUT_REG, 0, 1 = extra output register stage (read latency 2 instead of 1).
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = contents undefined, ready immediately.

Ports:
- clk  in  1  single clock for both ports.
- rst  in  1  synchronous reset, active-high.
- busy  out  1  high while the clear sequencer runs; port requests are ignored.
- a_en  in  1  port A request strobe.
- a_we  in  NB  port A lane write enables; a_en=1 with a_we=0 is a pure read.
- a_addr  in  ADDR_WIDTH  port A word address.
- a_din  in  DATA_WIDTH  port A write data.
- a_dout  out  DATA_WIDTH  port A read data.
- a_valid  out  1  port A a_dout holds the result of an accepted request.
- b_en, b_we, b_addr, b_din, b_dout, b_valid: identical to port A, for port B.

Behaviour:
- Reset (rst=1): a_dout=b_dout=0; a_valid=b_valid=0; clear counter=0; busy=CLEAR_ON_RESET. The memory array is not written while rst=1.
- FSM states are CLEAR and READY. After rst the FSM is in CLEAR if CLEAR_ON_RESET=1, otherwise in READY.
- CLEAR state:
  - Starting the first cycle after rst falls, write zero to mem[cnt] and increment cnt, one word per cycle.
  - After writing address 2**ADDR_WIDTH-1, go to READY. busy falls on the following edge, so busy stays high for exactly 2**ADDR_WIDTH cycles.
  - While busy=1, en is masked: no writes, valid stays 0, dout holds its value.
- Reset mid-clear: asserting rst restarts the sequence from address 0.
- READY state, request acceptance: a request is accepted when en=1 and busy=0.
- READY state, writes: on the accepting edge, mem[addr] lane i <= din lane i for each a_we[i]=1. Unselected lanes are unchanged.
- READY state, read latency:
  - OUT_REG=0: dout is updated on the accepting edge and valid=1 for the next cycle.
  - OUT_REG=1: data passes through one more register; dout and valid appear one cycle later.
  - Back-to-back requests give one result per cycle. valid=0 in any cycle with no accepted request at the matching latency. dout holds its last value when valid=0.
- Same-port read-during-write:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the post-write word: new lanes where we=1, old lanes elsewhere.
- Cross-port collision, same address, same cycle:
  - Both ports writing: port A wins on every lane both enable. Lanes enabled by only one port take that port's data.
  - One port writing, the other reading: the reader always gets old data (read-first), regardless of RDW_MODE.
- Addresses are ADDR_WIDTH wide and map to the full array, so there is no out-of-range case.

Decomposition:
- Shared package: RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1 constants; FSM state encoding (CLEAR, READY); NB derivation helper.
- One sub-module, bram_out_stage, instantiated once per port:
  - Takes raw read data plus an accept flag.
  - Implements the valid flag and the OUT_REG-optional register.
  - Resets dout and valid to 0.
- The array, collision resolution and clear FSM live in the top level.

Test Plan (ADDR_WIDTH=4, DATA_WIDTH=32, BYTE_W=8 unless noted):
- Clear: preload nonzero, pulse rst one cycle -> busy=1 for exactly 16 cycles. Then A reads addrs 0..15 -> all 0x00000000, a_valid one cycle after each request.
- Byte enables: A writes 0xAABBCCDD to addr 3 with we=1111, then 0x11223344 with we=0101 -> read of addr 3 returns 0xAA22CC44.
- RDW: addr 5 holds 0x1; A writes 0x2 and reads addr 5 in the same cycle -> returns 0x1 with RDW_MODE=0, 0x2 with RDW_MODE=1. The next read returns 0x2 in both modes.
- Collision: same cycle, A writes 0xFFFFFFFF with we=0011 and B writes 0x12345678 with we=1111 to addr 7 -> addr 7 = 0x1234FFFF. A separate case: B reads addr 7 while A writes it -> B gets the old value.
- OUT_REG=1: back-to-back A reads of addrs 1,2,3 with distinct data -> results appear at cycles +2,+3,+4 with a_valid high for exactly those three cycles.
- Reset mid-clear: assert rst at clear cycle 9 -> busy stays high. The count restarts, and busy falls 16 cycles after rst drops. A request issued during busy produces no write and a_valid=0.
